m_code_31_sync: RTL

M_CODE_31_SYNC -- requirements
Module: m_code_31_sync

---
 rtl/m_seq_pkg.sv | 25 ++
 rtl/m_seq_lfsr.sv | 38 +++
 rtl/m_code_31_sync.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/m_seq_pkg.sv
// -----------------------------------------------------------------------------
// m_seq_pkg
// Shared definitions for the 31-chip m-sequence generator and its receive-side
// synchroniser: LFSR width, seed, period, the synchroniser state encoding and
// the LFSR step function. Both ends of the link import this package so that
// the transmitted and replica sequences can never diverge.
// -----------------------------------------------------------------------------
package m_seq_pkg;

    localparam int                LFSR_W     = 5;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 5'b11111;
    localparam int                SEQ_PERIOD = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCK   = 2'd2
    } sync_state_t;

    // Fibonacci step: new MSB is Q[3]^Q[0], everything else shifts right.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[3] ^ q[0], q[4:1]};
    endfunction

endpackage

// File: rtl/m_seq_lfsr.sv
// -----------------------------------------------------------------------------
// m_seq_lfsr
// 5-bit maximal-length LFSR (period 31) with an advance enable and a
// synchronous reseed. Usable both as the transmit generator and as the local
// replica inside the synchroniser.
//
// Ports
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset (loads the seed)
//   adv     in  advance one chip on this clk
//   reseed  in  reload the seed on this clk (wins over adv)
//   chip    out current chip, Q[0]
// -----------------------------------------------------------------------------
module m_seq_lfsr
    import m_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    input  logic reseed,
    output logic chip
);

    logic [LFSR_W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (reseed) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

    assign chip = q[0];

endmodule

// File: rtl/m_code_31_sync.sv
// -----------------------------------------------------------------------------
// m_code_31_sync
// Serial-search code synchroniser for a 31-chip m-sequence. A local replica
// is correlated against the received chips over 31-chip windows. While
// searching, each failing window holds the replica back by one chip (a slip)
// so that every code phase is eventually tried. A window with at least
// THRESH matches declares lock; MISS_LIMIT consecutive failing windows in
// lock drop back to search.
//
// Parameters
//   THRESH      matches per window needed to count as correlated (0..31)
//   MISS_LIMIT  consecutive failing windows that lose lock (1..15)
//
// Ports
//   clk         in  clock
//   rst_n       in  asynchronous active-low reset
//   chip_stb    in  one-clk strobe marking a valid received chip
//   rx_chip     in  received chip, sampled when chip_stb=1
//   sync_en     in  enable; 0 forces IDLE and reseeds the replica
//   local_chip  out current replica chip
//   corr_cnt    out match count of the last completed window
//   locked      out high while in LOCK
//   slip        out one-clk pulse on the chip where the replica is held
//   state       out IDLE=0, SEARCH=1, LOCK=2
// -----------------------------------------------------------------------------
module m_code_31_sync
    import m_seq_pkg::*;
#(
    parameter int unsigned THRESH     = 29,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_stb,
    input  logic       rx_chip,
    input  logic       sync_en,
    output logic       local_chip,
    output logic [4:0] corr_cnt,
    output logic       locked,
    output logic       slip,
    output logic [1:0] state
);

    localparam logic [4:0] THRESH_L   = THRESH[4:0];
    localparam logic [3:0] MISS_LIM_L = MISS_LIMIT[3:0];
    localparam logic [4:0] WIN_LAST   = 5'(SEQ_PERIOD - 1);

    sync_state_t state_q, state_d;

    logic [4:0] win_cnt;
    logic [4:0] match_cnt;
    logic [4:0] corr_q;
    logic [3:0] miss_cnt, miss_d;
    logic       slip_arm, arm_set;

    logic       active;
    logic       slip_chip;
    logic       cnt_en;
    logic       win_end;
    logic [4:0] match_sum;
    logic       corr_ok;

    // A strobe is either consumed as the slip chip (replica held, nothing
    // counted) or correlated normally; never both.
    assign active    = sync_en && (state_q != ST_IDLE);
    assign slip_chip = active && chip_stb && slip_arm;
    assign cnt_en    = active && chip_stb && !slip_arm;
    assign win_end   = cnt_en && (win_cnt == WIN_LAST);

    // At most 30 matches are held before the last chip, so the final count
    // including the last chip tops out at 31 and fits without saturation.
    assign match_sum = match_cnt + {4'd0, rx_chip == local_chip};
    assign corr_ok   = (match_sum >= THRESH_L);

    m_seq_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (cnt_en),
        .reseed (!sync_en),
        .chip   (local_chip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decisions use the window total including the chip on this edge, so
    // locked and corr_cnt change together on the final strobe of a window.
    always_comb begin
        state_d = state_q;
        miss_d  = miss_cnt;
        arm_set = 1'b0;
        if (!sync_en) begin
            state_d = ST_IDLE;
            miss_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (win_end) begin
                        if (corr_ok) begin
                            state_d = ST_LOCK;
                            miss_d  = 4'd0;
                        end else begin
                            arm_set = 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (win_end) begin
                        if (corr_ok) begin
                            miss_d = 4'd0;
                        end else if ((miss_cnt + 4'd1) >= MISS_LIM_L) begin
                            state_d = ST_SEARCH;
                            miss_d  = 4'd0;
                            arm_set = 1'b1;
                        end else begin
                            miss_d = miss_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= 5'd0;
            match_cnt <= 5'd0;
            corr_q    <= 5'd0;
            miss_cnt  <= 4'd0;
            slip_arm  <= 1'b0;
        end else begin
            miss_cnt <= miss_d;
            if (!sync_en) begin
                // corr_q deliberately survives a disable.
                win_cnt   <= 5'd0;
                match_cnt <= 5'd0;
                slip_arm  <= 1'b0;
            end else begin
                if (slip_chip) begin
                    slip_arm <= 1'b0;
                end else if (arm_set) begin
                    slip_arm <= 1'b1;
                end
                if (cnt_en) begin
                    if (win_end) begin
                        corr_q    <= match_sum;
                        win_cnt   <= 5'd0;
                        match_cnt <= 5'd0;
                    end else begin
                        win_cnt   <= win_cnt + 5'd1;
                        match_cnt <= match_sum;
                    end
                end
            end
        end
    end

    assign corr_cnt = corr_q;
    assign locked   = (state_q == ST_LOCK);
    assign slip     = slip_chip;
    assign state    = state_q;

endmodule
